// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D convolution over an IMG_W x IMG_H raster frame with saturated output.
// Optional build macro CONV2D_STREAM_RELU_EN clamps negative results to zero.
module conv2d_stream #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 7,
  parameter int IMG_H = 7,
  parameter int OW    = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_wr,
  input  logic [$clog2(K*K)-1:0]   w_addr,
  input  logic [WW-1:0]            w_data,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int NW   = K * K;
  localparam int ACCW = DW + WW + $clog2(K * K);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic signed [WW-1:0] weight [NW];
  logic signed [DW-1:0] win    [K][K];
  logic signed [DW-1:0] win_d  [K][K];
  logic signed [DW-1:0] lbuf   [K-1][IMG_W];
  logic signed [DW-1:0] col_vec [K];

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          last_px;
  logic          win_done;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] res;

  assign accept   = in_valid && in_ready;
  assign last_px  = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
  assign win_done = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  // NOTE: every output of a combinational block gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && last_px) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Column entering the window: K-1 older rows from the line buffers plus the live pixel.
  always_comb begin
    for (int j = 0; j < K - 1; j++) col_vec[j] = lbuf[j][col];
    col_vec[K-1] = signed'(in_data);
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win[r][c+1];
      win_d[r][K-1] = col_vec[r];
    end
  end

  // The MAC runs on the window as it will look after this pixel, giving one cycle of latency.
  always_comb begin
    acc = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        acc = acc + ACCW'(win_d[r][c]) * ACCW'(weight[r*K+c]);
  end

  always_comb begin
    if (acc > SAT_MAX)      res = SAT_MAX;
    else if (acc < SAT_MIN) res = SAT_MIN;
    else                    res = acc;
`ifdef CONV2D_STREAM_RELU_EN
    if (res[ACCW-1]) res = '0;
`else
`endif
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DRAIN) && out_valid && out_ready;

      if (state_q == IDLE && start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= last_px ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (accept && win_done) begin
        out_valid <= 1'b1;
        out_data  <= res[OW-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: weights, window and line buffers are cleared on reset so no stale frame data survives an abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) weight[i] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
      for (int j = 0; j < K - 1; j++)
        for (int x = 0; x < IMG_W; x++) lbuf[j][x] <= '0;
    end else begin
      if (state_q == IDLE && w_wr && int'(w_addr) < NW) weight[w_addr] <= signed'(w_data);
      if (accept) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) win[r][c] <= win_d[r][c];
        for (int j = 0; j < K - 2; j++) lbuf[j][col] <= lbuf[j+1][col];
        lbuf[K-2][col] <= signed'(in_data);
      end
    end
  end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 Parameter DW, default 8: signed input pixel width.
REQ-002 Parameter WW, default 8: signed kernel weight width.
REQ-003 Parameter K, default 3: kernel side, K×K window, K ≥ 2.
REQ-004 Parameter IMG_W, default 7: image width in pixels, ≥ K.
REQ-005 Parameter IMG_H, default 7: image height in pixels, ≥ K.
REQ-006 Parameter OW, default 13: signed output width.
REQ-007 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-low reset.
- w_wr  in  1  weight write strobe.
- w_addr  in  clog2(K*K)  weight index, row-major.
- w_data  in  WW  signed weight.
- start  in  1  frame start pulse.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accept.
- in_data  in  DW  signed pixel, row-major.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_data  out  OW  signed result.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.

Function
REQ-008 FSM states SHALL be IDLE, RUN, DRAIN. Transitions: IDLE→RUN on start; RUN→DRAIN when pixel IMG_W*IMG_H-1 is accepted; DRAIN→IDLE when the final result handshakes.
REQ-009 In IDLE, w_wr SHALL write w_data to weight[w_addr]. In RUN and DRAIN, w_wr SHALL be ignored.
REQ-010 w_wr and start in the same IDLE cycle SHALL both take effect.
REQ-011 start outside IDLE SHALL be ignored.
REQ-012 in_ready SHALL be 1 only in RUN with (!out_valid || out_ready).
REQ-013 A pixel SHALL be accepted on in_valid && in_ready.
REQ-014 Accepted pixels SHALL shift into K-1 line buffers of IMG_W entries and a K×K window register.
REQ-015 Column and row counters SHALL track the accepted pixel. The column wraps at IMG_W-1 and increments the row.
REQ-016 A window SHALL be complete when the accepted pixel has row ≥ K-1 and col ≥ K-1. Windows straddling the row wrap SHALL NOT be produced.
REQ-017 Result SHALL be Σ weight[i]·pixel[i] over the window, with pixel[0] the top-left pixel (oldest row, oldest column).
REQ-018 The accumulator width SHALL be DW+WW+clog2(K*K), so it never overflows.
REQ-019 The result SHALL saturate to the OW signed range [-2^(OW-1), 2^(OW-1)-1].
REQ-020 out_data and out_valid SHALL register one cycle after the completing pixel is accepted (latency 1).
REQ-021 out_valid SHALL hold, with out_data stable, until out_ready.
REQ-022 A frame SHALL emit exactly (IMG_W-K+1)*(IMG_H-K+1) results in raster order.
REQ-023 busy SHALL be 1 in RUN and DRAIN.
REQ-024 done SHALL pulse for one cycle on the cycle after the final result handshake, coincident with the return to IDLE.
REQ-025 Weights SHALL persist across frames.

Reset
REQ-026 On rst=0 at a clock edge:
- state to IDLE;
- counters, window and line buffers to 0;
- all weights to 0;
- in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-027 rst=0 mid-frame SHALL abort the frame with no further outputs and no done pulse.

Configuration
REQ-028 With macro CONV2D_STREAM_RELU_EN defined, negative saturated results SHALL output as 0. Without it, signed results pass unmodified.

Verification
REQ-029 All weights 1, all pixels 1, out_ready=1 → 25 results each 9 (default params), then one done pulse, busy=0.
REQ-030 Identity kernel (weight[4]=1, others 0), pixel=row*7+col → results 8,9,10,11,12,15,…,40, in raster order.
REQ-031 All pixels 127, all weights 127 → every result 4095 (saturated). Pixels 127, weights -128 → -4096 without the macro, 0 with CONV2D_STREAM_RELU_EN.
REQ-032 Ones-frame with out_ready held 0 for 10 cycles mid-frame → in_ready=0 throughout, out_data stable, no result lost or duplicated, 25 results total.
REQ-033 rst=0 after 20 pixels, then a fresh weight load and start → no stale outputs, correct 25 results, single done.
REQ-034 w_wr during RUN with w_data=5 → weight unchanged, frame results unaffected.
